// File: rtl/ysyx_imm_decode_stage.sv
// Immediate decode stage: decodes format/immediate at push time and
// buffers entries in a small FIFO toward the execute stage.
module ysyx_imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam bit RV64 = (XLEN == 64);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_Z = 3'd6;
    localparam logic [2:0] FMT_X = 3'd7;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
    } entry_t;

    logic [6:0]  opc;
    logic        is_r, is_i, is_s, is_b, is_u, is_j, is_z;
    logic [2:0]  fmt_d;
    logic [63:0] imm64;
    logic        s;

    assign opc = in_inst[6:0];
    assign s   = in_inst[31];

    // Every listed opcode ends in 2'b11, so compressed encodings fall out as illegal.
    always_comb begin
        is_u = (opc == 7'b0110111) || (opc == 7'b0010111);
        is_j = (opc == 7'b1101111);
        is_s = (opc == 7'b0100011);
        is_b = (opc == 7'b1100011);
        is_z = (opc == 7'b1110011) && in_inst[14];
        is_r = (opc == 7'b0110011) ||
               (RV64 && (opc == 7'b0111011));
        is_i = (opc == 7'b1100111) || (opc == 7'b0000011) ||
               (opc == 7'b0010011) || (opc == 7'b0001111) ||
               (RV64 && (opc == 7'b0011011)) ||
               ((opc == 7'b1110011) && !in_inst[14]);
    end

    always_comb begin
        fmt_d = FMT_X;
        unique case (1'b1)
            is_r:    fmt_d = FMT_R;
            is_i:    fmt_d = FMT_I;
            is_s:    fmt_d = FMT_S;
            is_b:    fmt_d = FMT_B;
            is_u:    fmt_d = FMT_U;
            is_j:    fmt_d = FMT_J;
            is_z:    fmt_d = FMT_Z;
            default: fmt_d = FMT_X;
        endcase
    end

    always_comb begin
        imm64 = '0;
        case (fmt_d)
            FMT_I: imm64 = {{52{s}}, in_inst[31:20]};
            FMT_S: imm64 = {{52{s}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: imm64 = {{51{s}}, s, in_inst[7], in_inst[30:25],
                            in_inst[11:8], 1'b0};
            FMT_J: imm64 = {{43{s}}, s, in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
            FMT_U: imm64 = {{32{s}}, in_inst[31:12], 12'b0};
            FMT_Z: imm64 = {59'b0, in_inst[19:15]};
            default: imm64 = '0;
        endcase
    end

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push, pop;
    entry_t          head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{inst: in_inst, pc: in_pc,
                                 imm: imm64[XLEN-1:0], fmt: fmt_d};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign out_inst    = out_valid ? head.inst : '0;
    assign out_pc      = out_valid ? head.pc   : '0;
    assign out_imm     = out_valid ? head.imm  : '0;
    assign out_fmt     = out_valid ? head.fmt  : '0;
    assign out_illegal = out_valid && (head.fmt == FMT_X);

endmodule
